// File: rtl/sampler_pkg.sv
// Shared constants and note-decode helpers for the note synthesiser.
package sampler_pkg;

    localparam int NOTE_COUNT = 9;
    localparam int GAIN_MAX   = 255;
    localparam int INC_W      = 24;

    typedef logic [NOTE_COUNT-1:0] note_vec_t;
    typedef logic [7:0]            gain_t;

    // Phase increments round(f * 2^24 / 48000), indexed by note bus bit position.
    localparam logic [INC_W-1:0] PHASE_INC [0:NOTE_COUNT-1] = '{
        24'd205286,  // bit0 o D5
        24'd182889,  // bit1 i C5
        24'd172623,  // bit2 u B4
        24'd153791,  // bit3 y A4
        24'd137014,  // bit4 t G4
        24'd122065,  // bit5 r F4
        24'd115214,  // bit6 e E4
        24'd102642,  // bit7 w D4
        24'd91446    // bit8 q C4
    };

    // A note is held only when exactly one key is pressed.
    function automatic logic note_is_single(input note_vec_t notes);
        return ($countones(notes) == 1);
    endfunction

    // Bit position of the pressed key; only meaningful when note_is_single().
    function automatic logic [3:0] note_index(input note_vec_t notes);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NOTE_COUNT; i++) begin
            if (notes[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module sample_tick_gen #(
    parameter int TICK_DIV = 1041
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap on the tick cycle.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/note_synth.sv
// Square-wave tone generator with attack/release envelope, driven by the
// one-hot note bus and delivering signed PCM samples over valid/ready.
module note_synth
    import sampler_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int SAMPLE_HZ    = 48000,
    parameter int TICK_DIV     = CLK_HZ / SAMPLE_HZ,
    parameter int SAMPLE_W     = 24,
    parameter int PHASE_W      = 24,
    parameter int AMPLITUDE    = 1048576,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 16
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NOTE_COUNT-1:0]      note_in,
    output logic signed [SAMPLE_W-1:0] sample_data,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic                       active,
    output logic                       overrun
);

    localparam int PROD_W = SAMPLE_W + 8;

    logic                       tick;
    logic                       held;
    logic [8:0]                 gain_sum, gain_dif;
    gain_t                      gain_q, gain_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic [PHASE_W-1:0]         inc_q, inc_d;
    logic [PROD_W-1:0]          prod;
    logic [SAMPLE_W-1:0]        mag;
    logic signed [SAMPLE_W-1:0] sample_next;
    logic signed [SAMPLE_W-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       active_q, active_d;
    logic                       over_q, over_d;
    logic                       unused_prod_lsbs;

    sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick)
    );

    assign held     = note_is_single(note_in);
    assign gain_sum = {1'b0, gain_q} + 9'(ATTACK_STEP);
    assign gain_dif = {1'b0, gain_q} - 9'(RELEASE_STEP);

    // Envelope and oscillator next state; everything advances only on a tick.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gain_d  = gain_q;
        phase_d = phase_q;
        inc_d   = inc_q;
        if (tick) begin
            if (held) begin
                inc_d  = PHASE_W'(PHASE_INC[note_index(note_in)]);
                gain_d = (gain_sum > 9'(GAIN_MAX)) ? gain_t'(GAIN_MAX) : gain_sum[7:0];
            end else begin
                // Silent: keep the old increment so the release tail holds its pitch.
                gain_d = gain_dif[8] ? '0 : gain_dif[7:0];
            end
            phase_d = (gain_d == '0) ? '0 : phase_q + inc_d;
        end
    end

    // Magnitude scales with gain; the square wave's sign is the phase MSB.
    assign prod             = PROD_W'(AMPLITUDE) * PROD_W'(gain_d);
    assign mag              = prod[PROD_W-1:8];
    assign sample_next      = phase_d[PHASE_W-1] ? $signed(mag) : -$signed(mag);
    assign unused_prod_lsbs = ^prod[7:0];

    // Output register and handshake: a tick always loads, otherwise a transfer empties.
    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        active_d = active_q;
        over_d   = over_q;
        if (tick) begin
            data_d   = sample_next;
            valid_d  = 1'b1;
            active_d = (gain_d != '0);
            if (valid_q && !sample_ready) over_d = 1'b1;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset abandons any release tail.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gain_q   <= '0;
            phase_q  <= '0;
            inc_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            gain_q   <= gain_d;
            phase_q  <= phase_d;
            inc_q    <= inc_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            over_q   <= over_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign active       = active_q;
    assign overrun      = over_q;

endmodule
